// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: data/address widths, the I/O address
// and the controller state encoding.
package cpu_pkg;
  localparam int WIDTH = 64;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] IO_ADDR = 8'hFF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/ram_sp.sv
// Single-port word memory: synchronous write, registered read, no reset on the array.
module ram_sp #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int DEPTH = 256,
  parameter int AW    = cpu_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM, with a zeroing sweep
// after reset or on request and a memory-mapped output strobe at IO_ADDR.
module mem_arbiter
  import cpu_pkg::ADDR_W, cpu_pkg::state_t, cpu_pkg::CLEAR, cpu_pkg::RUN;
#(
  parameter int                WIDTH   = cpu_pkg::WIDTH,
  parameter int                DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_ADDR = cpu_pkg::IO_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [WIDTH-1:0]  p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WIDTH-1:0]  p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WIDTH-1:0]  p1_rdata,
  input  logic              clear_req,
  output logic              busy,
  output logic              io_write,
  output logic [WIDTH-1:0]  io_data
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] clr_q;
  logic              last_q;
  logic              rv0_q, rv1_q, io_write_q;
  logic [WIDTH-1:0]  hold0_q, hold1_q, io_data_q;

  logic              run, acc, acc_we, io_hit;
  logic [ADDR_W-1:0] acc_addr;
  logic [WIDTH-1:0]  acc_wdata;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata, ram_rdata;

  // last_q = 1 means port 1 won most recently, so port 0 takes the next tie
  assign run    = (state_q == RUN);
  assign p0_gnt = run && p0_req && (!p1_req || last_q);
  assign p1_gnt = run && p1_req && (!p0_req || !last_q);

  assign acc       = p0_gnt | p1_gnt;
  assign acc_we    = p0_gnt ? p0_we    : p1_we;
  assign acc_addr  = p0_gnt ? p0_addr  : p1_addr;
  assign acc_wdata = p0_gnt ? p0_wdata : p1_wdata;
  assign io_hit    = acc && acc_we && (acc_addr == IO_ADDR);

  assign ram_we    = run ? (acc && acc_we) : 1'b1;
  assign ram_re    = acc && !acc_we;
  assign ram_addr  = run ? acc_addr : clr_q;
  assign ram_wdata = run ? acc_wdata : '0;

  ram_sp #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      last_q     <= 1'b1;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      io_write_q <= 1'b0;
      io_data_q  <= '0;
    end else begin
      rv0_q      <= p0_gnt && !p0_we;
      rv1_q      <= p1_gnt && !p1_we;
      io_write_q <= io_hit;
      io_data_q  <= io_hit ? acc_wdata : '0;
      if (rv0_q) hold0_q <= ram_rdata;
      if (rv1_q) hold1_q <= ram_rdata;
      if (acc) last_q <= p1_gnt;
      case (state_q)
        CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == LAST_ADDR) state_q <= RUN;
        end
        RUN: begin
          if (clear_req) begin
            state_q <= CLEAR;
            clr_q   <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Read data is live from the RAM in the rvalid cycle and held afterwards
  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rv0_q ? ram_rdata : hold0_q;
  assign p1_rdata  = rv1_q ? ram_rdata : hold1_q;
  assign busy      = !run;
  assign io_write  = io_write_q;
  assign io_data   = io_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle monitor and per-port read scoreboards.
module tb_mem_arbiter;
  logic        clk, rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [7:0]  p0_addr;
  logic [63:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [7:0]  p1_addr;
  logic [63:0] p1_wdata, p1_rdata;
  logic        clear_req, busy, io_write;
  logic [63:0] io_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [256];
  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];
  logic [63:0] last0, last1, io_exp, e;
  logic        io_pend;

  mem_arbiter #(.WIDTH(64), .DEPTH(256), .IO_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .clear_req(clear_req), .busy(busy), .io_write(io_write), .io_data(io_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  // Counts cycles with busy high; optionally pulses clear_req at cycle mid
  task automatic count_busy(input int mid, output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 1000) begin
      n++;
      clear_req = (n == mid);
      @(negedge clk);
    end
    clear_req = 1'b0;
  endtask

  task automatic access(input bit p, input logic we, input logic [7:0] a, input logic [63:0] d);
    int n;
    @(posedge clk); #1;
    if (!p) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else    begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    n = 0;
    @(negedge clk);
    while (((p ? p1_gnt : p0_gnt) !== 1'b1) && n < 8) begin
      n++;
      @(negedge clk);
    end
    chk("gnt_same_cycle", 64'(n), 64'd0);
    @(posedge clk); #1;
    if (!p) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  // Per-cycle monitor: read latency/data, held rdata, IO strobe, grant exclusivity
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      exp0.delete();
      exp1.delete();
      io_pend = 1'b0;
      last0 = '0;
      last1 = '0;
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
      chk("rst_rdata0", p0_rdata, 64'd0);
      chk("rst_rdata1", p1_rdata, 64'd0);
      chk("rst_io", {63'd0, io_write} | io_data, 64'd0);
    end else begin
      chk("one_gnt", 64'(p0_gnt & p1_gnt), 64'd0);
      if (busy === 1'b1) chk("gnt_while_busy", {62'd0, p1_gnt, p0_gnt}, 64'd0);
      chk("rvalid0", 64'(p0_rvalid), 64'(exp0.size() > 0));
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        chk("rdata0", p0_rdata, e);
        last0 = e;
      end else chk("hold0", p0_rdata, last0);
      chk("rvalid1", 64'(p1_rvalid), 64'(exp1.size() > 0));
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        chk("rdata1", p1_rdata, e);
        last1 = e;
      end else chk("hold1", p1_rdata, last1);
      chk("io_write", 64'(io_write), 64'(io_pend));
      chk("io_data", io_data, io_pend ? io_exp : 64'd0);
      io_pend = 1'b0;
      if (p0_gnt === 1'b1 && p0_req) begin
        if (!p0_we) exp0.push_back(model[p0_addr]);
        else begin
          model[p0_addr] = p0_wdata;
          if (p0_addr == 8'hFF) begin io_pend = 1'b1; io_exp = p0_wdata; end
        end
      end
      if (p1_gnt === 1'b1 && p1_req) begin
        if (!p1_we) exp1.push_back(model[p1_addr]);
        else begin
          model[p1_addr] = p1_wdata;
          if (p1_addr == 8'hFF) begin io_pend = 1'b1; io_exp = p1_wdata; end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; clear_req = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    zero_model();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
    rst = 1'b1;
    count_busy(0, n);
    chk("init_sweep_cycles", 64'(n), 64'd256);

    access(1'b0, 1'b0, 8'd0, '0);
    access(1'b0, 1'b0, 8'd7, '0);
    access(1'b0, 1'b0, 8'd255, '0);

    access(1'b0, 1'b1, 8'd5, 64'h1234);
    access(1'b1, 1'b0, 8'd5, '0);

    // Both ports request together; port 1 won last, so port 0 leads
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd5;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_p0", 64'(p0_gnt), 64'((i % 2) == 0));
      chk("rr_p1", 64'(p1_gnt), 64'((i % 2) == 1));
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;

    access(1'b1, 1'b1, 8'd200, 64'hFEDC_BA98_7654_3210);
    access(1'b0, 1'b0, 8'd200, '0);

    access(1'b1, 1'b1, 8'hFF, 64'hDEAD_BEEF);
    access(1'b0, 1'b0, 8'hFF, '0);

    access(1'b0, 1'b1, 8'd3, 64'h55);
    access(1'b1, 1'b0, 8'd3, '0);

    // clear_req together with a granted read; the read still completes
    @(posedge clk); #1;
    clear_req = 1'b1; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd3;
    @(negedge clk);
    chk("gnt_with_clear", 64'(p0_gnt), 64'd1);
    @(posedge clk); #1;
    clear_req = 1'b0; p0_req = 1'b0;
    zero_model();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'd3;
    count_busy(50, n);
    chk("clear_sweep_cycles", 64'(n), 64'd256);
    chk("gnt_after_clear", 64'(p1_gnt), 64'd1);
    @(posedge clk); #1;
    p1_req = 1'b0;
    access(1'b0, 1'b0, 8'd3, '0);

    // Reset in the middle of a sweep with port 0 waiting
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    zero_model();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd5;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midsweep_rst_busy", 64'(busy), 64'd1);
    chk("midsweep_rst_gnt", 64'(p0_gnt), 64'd0);
    chk("midsweep_rst_rdata", p0_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    count_busy(0, n);
    chk("restart_sweep_cycles", 64'(n), 64'd256);
    chk("gnt_after_restart", 64'(p0_gnt), 64'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
